// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared state encoding, default baud divisor and counter sizing for the FIFO UART transmitter.
package fifo_uart_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
    localparam int CLKS_DEFAULT = 434;
    function automatic int cnt_w(int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/baud_counter.sv
// baud_counter: free-running bit-period counter with registered terminal-count tick and a one-early flag.
module baud_counter
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic near
);
    localparam int W = cnt_w(CLKS_PER_BIT);
    logic [W-1:0] cnt;
    // near lets the parent register outputs that must line up with tick
    assign near = ~clear & (cnt == W'(CLKS_PER_BIT - 2));
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (clear | tick) ? '0 : cnt + 1'b1;
            tick <= near;
        end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO and sends each as an LSB-first start/data/stop serial frame.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = CLKS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] poppedValue,
    output logic             pop,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int BW = cnt_w(WIDTH + 1);
    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [BW-1:0]    bits;
    logic             tick;
    logic             near;
    assign pop = (state == IDLE) & en & ~empty;
    baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE || state == FETCH),
        .tick  (tick),
        .near  (near)
    );
    // tx is loaded with the level of the state being entered so it stays a clean flop output
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            shift <= '0;
            bits  <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= (state == STOP) & near;
            case (state)
                IDLE:  if (pop) begin
                    state <= FETCH;
                    busy  <= 1'b1;
                end
                FETCH: begin
                    shift <= poppedValue;
                    state <= START;
                    tx    <= 1'b0;
                end
                START: if (tick) begin
                    state <= DATA;
                    bits  <= '0;
                    tx    <= shift[0];
                end
                DATA:  if (tick) begin
                    shift <= shift >> 1;
                    bits  <= bits + 1'b1;
                    state <= (bits == BW'(WIDTH - 1)) ? STOP : DATA;
                    tx    <= (bits == BW'(WIDTH - 1)) ? 1'b1 : shift[1];
                end
                STOP:  if (tick) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the 4-bit FIFO. It pops one word at a time through the FIFO's pop/empty/poppedValue interface. Each word goes out LSB-first as a UART-style serial frame: one start bit (0), WIDTH data bits, one stop bit (1). It sits between the FIFO and the board's serial/GPIO output pin.

Parameters:
WIDTH, 4, data word width; must match the FIFO width.
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range >= 2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
en  input  1  transmit enable; sampled only in IDLE.
empty  input  1  FIFO empty flag.
poppedValue  input  WIDTH  FIFO read data; valid the cycle after pop is high.
pop  output  1  one-cycle FIFO pop request.
tx  output  1  serial line; idles high.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse in the last cycle of a stop bit.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, tx=1, pop=0, busy=0, done=0, shift register=0, baud counter=0, bit counter=0.
- States: IDLE, FETCH, START, DATA, STOP. Encoded as an enum.
- IDLE:
  - tx=1.
  - pop = en & ~empty, driven combinationally from state and inputs.
  - When pop=1, next state is FETCH.
  - pop is never high outside IDLE.
  - pop is never high while empty=1.
- FETCH, exactly 1 cycle:
  - Load poppedValue into the WIDTH-bit shift register.
  - Clear the baud counter.
  - Next state START. tx stays 1.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - On the baud counter's terminal count (CLKS_PER_BIT-1): next state DATA, clear the bit counter.
- DATA:
  - tx = shift[0].
  - At each terminal count: shift right by 1 and increment the bit counter.
  - After WIDTH bits: next state STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - done=1 on the terminal-count cycle only.
  - Next state IDLE.
- Timing:
  - tx falls 2 cycles after the pop cycle: pop at cycle t, FETCH at t+1, first START cycle at t+2.
  - A frame is (WIDTH+2)*CLKS_PER_BIT cycles.
  - Back-to-back words: line stays high for 2 cycles (IDLE + FETCH) beyond the stop bit.
- Counter widths: baud counter $clog2(CLKS_PER_BIT); bit counter $clog2(WIDTH+1). Both wrap-free; cleared on every state entry.
- en deasserted mid-frame: the frame completes and no further pop occurs.
- empty going high mid-frame: no effect on the current frame.
- Reset mid-frame: tx returns to 1 immediately. The popped word is discarded, not re-queued.
- The output registers (tx, done) are glitch-free. pop is the only combinational output.

Decomposition:
- Package fifo_uart_pkg:
  - state_t enum {IDLE, FETCH, START, DATA, STOP}.
  - Default CLKS_PER_BIT constant.
  - Function for counter width.
- Sub-module baud_counter:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, reset, clear.
  - Output tick, high on terminal count.
  - Counter auto-reloads to 0.

Test Plan:
- Reset while idle, with CLKS_PER_BIT=4 used for simulation: reset=0 -> tx=1, pop=0, busy=0, done=0; these hold after release with empty=1.
- Single word: FIFO holds 4'b1010, en=1 -> pop for 1 cycle. tx = 0 (4 cycles), then 0,1,0,1 (4 cycles each), then 1 (4 cycles). done pulses at cycle 24 after FETCH. busy is high for 25 cycles.
- Back-to-back: FIFO holds 4'h3 then 4'hC -> two frames with exactly 2 extra high cycles between the stop bit and the next start bit. Exactly 2 pop pulses. empty=1 afterwards -> stays in IDLE.
- en gating: en=0 with the FIFO non-empty -> no pop, tx=1. Deassert en during the DATA of a 4'hF frame -> the frame finishes, and no second pop occurs.
- Reset mid-frame: assert reset during bit 2 of 4'h5 -> tx=1 asynchronously and state=IDLE. After release with en=1 and FIFO non-empty, the next pop transmits the next word.
- Empty guard: randomized push/pop traffic -> pop never asserted while empty=1 or while busy=1; serial decode of tx matches push order.
